// File: rtl/gate_tt_sequencer.sv
// gate_tt_sequencer
//   Self-test driver and checker for a 2-input basic-gates stage. On start it
//   drives {a_out,b_out} through 00,01,10,11 (idx = {a,b}). It waits
//   SETTLE_CYCLES edges after each drive edge, then captures the stage's
//   7-bit y output, logs it and compares it against the golden truth table.
//   It reports a sticky per-output error mask and a pass flag.
//
// Ports
//   clk       in   1   single clock, rising edge
//   rst       in   1   synchronous, active-high reset
//   start     in   1   begin a sweep; sampled only in IDLE or DONE
//   y_in      in   7   gate outputs: [0]~a [1]and [2]or [3]nand [4]nor [5]xor [6]xnor
//   a_out     out  1   gate input a (registered)
//   b_out     out  1   gate input b (registered)
//   busy      out  1   sweep in progress
//   done      out  1   sweep complete; held until next accepted start or rst
//   pass      out  1   err_mask==0, valid while done=1, otherwise 0
//   err_mask  out  7   sticky per-output mismatch flags
//   vec_idx   out  2   vector currently driven / being checked
//   y_log     out  28  captured y per vector, y_log[7*i +: 7] for vector i
module gate_tt_sequencer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [6:0]  y_in,
  output logic        a_out,
  output logic        b_out,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [6:0]  err_mask,
  output logic [1:0]  vec_idx,
  output logic [27:0] y_log
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  // With no settle time a drive edge leads straight into the capture cycle.
  localparam state_t     AFTER_DRIVE = (SETTLE_CYCLES == 0) ? CAPTURE : SETTLE;
  // Count value on which the last settle edge occurs.
  localparam logic [7:0] SETTLE_LAST = (SETTLE_CYCLES == 0) ? 8'd0 : 8'(SETTLE_CYCLES - 1);

  state_t      state_r;
  state_t      state_s;
  logic [7:0]  cnt_r;
  logic [7:0]  cnt_s;
  logic        a_s;
  logic        b_s;
  logic        busy_s;
  logic        done_s;
  logic        pass_s;
  logic [6:0]  err_s;
  logic [6:0]  cap_err_s;
  logic [1:0]  idx_s;
  logic [27:0] ylog_s;

  // Expected gate-stage output for vector idx = {a,b}.
  function automatic logic [6:0] golden(input logic [1:0] idx);
    logic [6:0] g;
    case (idx)
      2'd0:    g = 7'h59;
      2'd1:    g = 7'h2D;
      2'd2:    g = 7'h2C;
      2'd3:    g = 7'h46;
      default: g = 7'h00;
    endcase
    return g;
  endfunction

  // Next-state and next-output logic for the sweep FSM.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    a_s       = a_out;
    b_s       = b_out;
    busy_s    = busy;
    done_s    = done;
    pass_s    = pass;
    err_s     = err_mask;
    idx_s     = vec_idx;
    ylog_s    = y_log;
    // Error mask including the vector being captured this cycle; used both
    // for the sticky update and for the final pass decision.
    cap_err_s = err_mask | (y_in ^ golden(vec_idx));

    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          state_s = AFTER_DRIVE;
          cnt_s   = 8'd0;
          a_s     = 1'b0;
          b_s     = 1'b0;
          busy_s  = 1'b1;
          done_s  = 1'b0;
          pass_s  = 1'b0;
          err_s   = 7'd0;
          idx_s   = 2'd0;
          ylog_s  = 28'd0;
        end else begin
          state_s = state_r;
        end
      end

      SETTLE: begin
        cnt_s = cnt_r + 8'd1;
        if (cnt_r == SETTLE_LAST) begin
          state_s = CAPTURE;
        end else begin
          state_s = SETTLE;
        end
      end

      CAPTURE: begin
        err_s = cap_err_s;
        for (int i = 0; i < 4; i++) begin
          if (vec_idx == 2'(i)) begin
            ylog_s[7*i +: 7] = y_in;
          end else begin
            ylog_s[7*i +: 7] = y_log[7*i +: 7];
          end
        end
        if (vec_idx != 2'd3) begin
          state_s      = AFTER_DRIVE;
          idx_s        = vec_idx + 2'd1;
          {a_s, b_s}   = vec_idx + 2'd1;
          cnt_s        = 8'd0;
        end else begin
          state_s = DONE;
          idx_s   = 2'd0;
          a_s     = 1'b0;
          b_s     = 1'b0;
          busy_s  = 1'b0;
          done_s  = 1'b1;
          pass_s  = (cap_err_s == 7'd0);
        end
      end

      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything including partial results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      cnt_r    <= 8'd0;
      a_out    <= 1'b0;
      b_out    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err_mask <= 7'd0;
      vec_idx  <= 2'd0;
      y_log    <= 28'd0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      a_out    <= a_s;
      b_out    <= b_s;
      busy     <= busy_s;
      done     <= done_s;
      pass     <= pass_s;
      err_mask <= err_s;
      vec_idx  <= idx_s;
      y_log    <= ylog_s;
    end
  end

endmodule

// File: tb/tb_gate_tt_sequencer.sv
// Testbench for gate_tt_sequencer: two instances (SETTLE_CYCLES=2 and 0)
// driven by shared start/rst, each fed by a behavioural gate stage with
// optional fault injection. A sweep-level reference model predicts timing
// and results; expectations are queued on acceptance and popped on done.
module tb_gate_tt_sequencer;

  typedef struct {
    int unsigned cyc;
    logic [6:0]  err;
    logic [27:0] ylog;
    logic        pass;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [6:0]  y_w    [2];
  logic        a_w    [2];
  logic        b_w    [2];
  logic        busy_w [2];
  logic        done_w [2];
  logic        pass_w [2];
  logic [6:0]  err_w  [2];
  logic [1:0]  idx_w  [2];
  logic [27:0] ylog_w [2];

  int          n_chk = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;
  logic        mon_en = 1'b0;

  logic [6:0]  f_clr;
  logic [6:0]  f_set;
  logic [6:0]  f_xor [4];

  logic        m_valid [2];
  int unsigned m_start [2];
  int unsigned m_end   [2];
  exp_t        q0[$];
  exp_t        q1[$];

  gate_tt_sequencer #(.SETTLE_CYCLES(2)) dut0 (
    .clk(clk), .rst(rst), .start(start), .y_in(y_w[0]),
    .a_out(a_w[0]), .b_out(b_w[0]), .busy(busy_w[0]), .done(done_w[0]),
    .pass(pass_w[0]), .err_mask(err_w[0]), .vec_idx(idx_w[0]), .y_log(ylog_w[0])
  );

  gate_tt_sequencer #(.SETTLE_CYCLES(0)) dut1 (
    .clk(clk), .rst(rst), .start(start), .y_in(y_w[1]),
    .a_out(a_w[1]), .b_out(b_w[1]), .busy(busy_w[1]), .done(done_w[1]),
    .pass(pass_w[1]), .err_mask(err_w[1]), .vec_idx(idx_w[1]), .y_log(ylog_w[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int settle_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  // Ideal gate behaviour from the boolean definitions.
  function automatic logic [6:0] good_y(input logic a, input logic b);
    return {~(a ^ b), a ^ b, ~(a | b), ~(a & b), a | b, a & b, ~a};
  endfunction

  // Gate stage as seen by the DUT, with the currently injected faults.
  function automatic logic [6:0] obs(input logic [1:0] i);
    return ((good_y(i[1], i[0]) & ~f_clr) | f_set) ^ f_xor[i];
  endfunction

  always_comb begin
    y_w[0] = obs({a_w[0], b_w[0]});
    y_w[1] = obs({a_w[1], b_w[1]});
  end

  task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s dut%0d actual=%h required=%h cyc=%0d", name, d, act, req, cyc);
    end
  endtask

  function automatic exp_t make_exp(input int unsigned endc);
    exp_t ex;
    logic [6:0] o;
    ex.cyc  = endc;
    ex.err  = 7'd0;
    ex.ylog = 28'd0;
    for (int i = 0; i < 4; i++) begin
      o = obs(2'(i));
      ex.ylog[7*i +: 7] = o;
      ex.err = ex.err | (o ^ good_y(i[1], i[0]));
    end
    ex.pass = (ex.err == 7'd0);
    return ex;
  endfunction

  // One clock: present start/rst for the coming edge, then update the model.
  task automatic step(input logic st, input logic rs);
    int unsigned e;
    logic        acc [2];
    exp_t        ex;
    start = st;
    rst   = rs;
    e     = cyc + 1;
    for (int d = 0; d < 2; d++)
      acc[d] = st && !rs && !(m_valid[d] && cyc >= m_start[d] && cyc < m_end[d]);
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rs) begin
        m_valid[d] = 1'b0;
        if (d == 0) q0.delete(); else q1.delete();
      end else if (acc[d]) begin
        m_valid[d] = 1'b1;
        m_start[d] = e;
        m_end[d]   = e + 4 * (settle_of(d) + 1);
        ex = make_exp(m_end[d]);
        if (d == 0) q0.push_back(ex); else q1.push_back(ex);
      end
    end
    #1;
  endtask

  function automatic bit all_idle();
    for (int d = 0; d < 2; d++)
      if (m_valid[d] && cyc < m_end[d]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (all_idle()) begin
        ok = 1'b1;
        break;
      end
      step(1'b0, 1'b0);
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_idle timeout actual=busy required=idle cyc=%0d", cyc);
    end
  endtask

  task automatic run_sweep();
    step(1'b1, 1'b0);
    wait_idle();
  endtask

  // Monitor: per-cycle protocol checks plus scoreboard pop on done rising.
  initial begin
    logic       prev_done [2];
    exp_t       ex;
    bit         got;
    logic [1:0] kk;
    prev_done[0] = 1'b0;
    prev_done[1] = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        for (int d = 0; d < 2; d++) begin
          if (!m_valid[d]) begin
            chk("reset_zero", d,
                64'({a_w[d], b_w[d], busy_w[d], done_w[d], pass_w[d], err_w[d], idx_w[d], ylog_w[d]}), 64'd0);
          end else if (cyc < m_end[d]) begin
            kk = 2'((cyc - m_start[d]) / (settle_of(d) + 1));
            chk("sweep_ctl", d, 64'({busy_w[d], done_w[d], pass_w[d], a_w[d], b_w[d], idx_w[d]}),
                64'({1'b1, 1'b0, 1'b0, kk[1], kk[0], kk}));
            if (cyc == m_start[d])
              chk("start_clear", d, 64'({err_w[d], ylog_w[d]}), 64'd0);
          end else begin
            chk("done_ctl", d, 64'({busy_w[d], done_w[d], a_w[d], b_w[d], idx_w[d]}),
                64'({1'b0, 1'b1, 1'b0, 1'b0, 2'd0}));
          end

          if (done_w[d] === 1'b1 && prev_done[d] !== 1'b1) begin
            got = 1'b0;
            if (d == 0) begin
              if (q0.size() > 0) begin ex = q0.pop_front(); got = 1'b1; end
            end else begin
              if (q1.size() > 0) begin ex = q1.pop_front(); got = 1'b1; end
            end
            if (!got) begin
              n_chk++;
              n_fail++;
              $display("FAIL sb_unexpected_done dut%0d actual=done required=no_done cyc=%0d", d, cyc);
            end else begin
              chk("sb_done_cycle", d, 64'(cyc), 64'(ex.cyc));
              chk("sb_err_mask", d, 64'(err_w[d]), 64'(ex.err));
              chk("sb_y_log", d, 64'(ylog_w[d]), 64'(ex.ylog));
              chk("sb_pass", d, 64'(pass_w[d]), 64'(ex.pass));
            end
          end
          prev_done[d] = done_w[d];
        end
      end
    end
  end

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    f_clr      = 7'd0;
    f_set      = 7'd0;
    for (int i = 0; i < 4; i++) f_xor[i] = 7'd0;
    m_valid[0] = 1'b0;
    m_valid[1] = 1'b0;
    m_start[0] = 0; m_start[1] = 0;
    m_end[0]   = 0; m_end[1]   = 0;

    step(1'b0, 1'b1);
    mon_en = 1'b1;
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);

    // Fault-free sweep.
    run_sweep();
    chk("t1_y_log", 0, 64'(ylog_w[0]), 64'(28'h8CB16D9));
    chk("t1_err", 0, 64'(err_w[0]), 64'd0);
    chk("t1_pass", 0, 64'(pass_w[0]), 64'd1);
    chk("t1_y_log", 1, 64'(ylog_w[1]), 64'(28'h8CB16D9));

    // AND output stuck at 0.
    f_clr = 7'b0000010;
    run_sweep();
    chk("t2_err", 0, 64'(err_w[0]), 64'(7'b0000010));
    chk("t2_pass", 0, 64'(pass_w[0]), 64'd0);
    chk("t2_vec3", 0, 64'(ylog_w[0][27:21]), 64'(7'h44));

    // XOR output stuck at 1.
    f_clr = 7'd0;
    f_set = 7'b0100000;
    run_sweep();
    chk("t3_err", 0, 64'(err_w[0]), 64'(7'b0100000));
    chk("t3_pass", 0, 64'(pass_w[0]), 64'd0);
    chk("t3_vec0", 0, 64'(ylog_w[0][6:0]), 64'(7'h79));
    chk("t3_vec3", 0, 64'(ylog_w[0][27:21]), 64'(7'h66));
    chk("t3_vec2", 0, 64'(ylog_w[0][20:14]), 64'(7'h2C));

    // Second start during SETTLE of vector 2 must be ignored by dut0.
    f_set = 7'd0;
    step(1'b1, 1'b0);
    repeat (6) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    wait_idle();
    chk("t4_y_log", 0, 64'(ylog_w[0]), 64'(28'h8CB16D9));
    chk("t4_pass", 0, 64'(pass_w[0]), 64'd1);

    // Reset on the ending edge of vector-1 CAPTURE, then a fresh sweep.
    step(1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("t5_all_zero", 0,
        64'({a_w[0], b_w[0], busy_w[0], done_w[0], pass_w[0], err_w[0], idx_w[0], ylog_w[0]}), 64'd0);
    f_clr = 7'b1000001;
    run_sweep();
    chk("t5_err", 0, 64'(err_w[0]), 64'(7'b1000001));

    // start held high: back-to-back sweeps with clearing on each restart.
    f_clr = 7'd0;
    repeat (16) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    wait_idle();
    chk("t6_y_log", 1, 64'(ylog_w[1]), 64'(28'h8CB16D9));
    chk("t6_done", 1, 64'(done_w[1]), 64'd1);

    // Randomized faults, start pulses and occasional resets.
    for (int it = 0; it < 40; it++) begin
      wait_idle();
      f_clr = 7'd0;
      f_set = 7'd0;
      for (int i = 0; i < 4; i++) f_xor[i] = 7'd0;
      case ($urandom_range(0, 3))
        0:       f_clr = 7'($urandom);
        1:       f_set = 7'($urandom);
        2:       for (int i = 0; i < 4; i++) f_xor[i] = 7'($urandom);
        default: f_clr = 7'd0;
      endcase
      repeat ($urandom_range(1, 30))
        step($urandom_range(0, 3) == 0, $urandom_range(0, 60) == 0);
    end

    wait_idle();
    step(1'b0, 1'b0);
    chk("sb_q0_empty", 0, 64'(q0.size()), 64'd0);
    chk("sb_q1_empty", 1, 64'(q1.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
